// File: rtl/rf_wb_arbiter.sv
// Writeback scheduler sharing the register-file write port between an ALU source (A) and a load source (B).
// Optional combinational forwarding from buffers/output register is enabled by defining RF_WB_FORWARD_EN.
module rf_wb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
`ifdef RF_WB_FORWARD_EN
  input  logic [ADDR_W-1:0] fwd_addr1,
  input  logic [ADDR_W-1:0] fwd_addr2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2,
`endif
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [CNT_W-1:0]  conflict_cnt,
  output logic              idle
);

  logic              a_full_q, a_full_d, b_full_q, b_full_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic [DATA_W-1:0] a_data_q, a_data_d, b_data_q, b_data_d;
  // age_diff: both buffered entries arrived in different cycles; older_b: B is the older one
  logic              age_diff_q, age_diff_d, older_b_q, older_b_d;
  logic              last_b_q, last_b_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              idle_q, idle_d;

  logic              grant_a_c, grant_b_c, a_xfer_c, b_xfer_c;
  logic [ADDR_W-1:0] g_addr_c;
  logic [DATA_W-1:0] g_data_c;

  // Grant: lone entry wins; otherwise the older; on equal age the side opposite last_grant
  always_comb begin
    grant_a_c = 1'b0;
    grant_b_c = 1'b0;
    if (a_full_q && b_full_q) begin
      if (age_diff_q) begin
        grant_a_c = !older_b_q;
        grant_b_c = older_b_q;
      end else begin
        grant_a_c = last_b_q;
        grant_b_c = !last_b_q;
      end
    end else begin
      grant_a_c = a_full_q;
      grant_b_c = b_full_q;
    end
  end

  assign a_ready  = !a_full_q || grant_a_c;
  assign b_ready  = !b_full_q || grant_b_c;
  assign a_xfer_c = a_valid && a_ready;
  assign b_xfer_c = b_valid && b_ready;
  assign g_addr_c = grant_b_c ? b_addr_q : a_addr_q;
  assign g_data_c = grant_b_c ? b_data_q : a_data_q;

  always_comb begin
    a_full_d   = a_full_q;
    a_addr_d   = a_addr_q;
    a_data_d   = a_data_q;
    b_full_d   = b_full_q;
    b_addr_d   = b_addr_q;
    b_data_d   = b_data_q;
    age_diff_d = age_diff_q;
    older_b_d  = older_b_q;
    last_b_d   = last_b_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    cnt_d      = cnt_q;

    if (grant_a_c) a_full_d = 1'b0;
    if (grant_b_c) b_full_d = 1'b0;
    if (a_xfer_c) begin
      a_full_d = 1'b1;
      a_addr_d = a_addr;
      a_data_d = a_data;
    end
    if (b_xfer_c) begin
      b_full_d = 1'b1;
      b_addr_d = b_addr;
      b_data_d = b_data;
    end

    // A new entry landing next to a held one is younger; simultaneous captures tie
    if (a_full_d && b_full_d) begin
      if (a_xfer_c || b_xfer_c) begin
        age_diff_d = a_xfer_c ^ b_xfer_c;
        older_b_d  = a_xfer_c;
      end
    end else begin
      age_diff_d = 1'b0;
      older_b_d  = 1'b0;
    end

    if (grant_a_c || grant_b_c) begin
      last_b_d  = grant_b_c;
      wr_en_d   = (g_addr_c != ADDR_W'(0));
      wr_addr_d = g_addr_c;
      wr_data_d = g_data_c;
    end

    if (a_full_q && b_full_q && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);

    idle_d = !a_full_d && !b_full_d && !wr_en_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_full_q   <= 1'b0;
      a_addr_q   <= '0;
      a_data_q   <= '0;
      b_full_q   <= 1'b0;
      b_addr_q   <= '0;
      b_data_q   <= '0;
      age_diff_q <= 1'b0;
      older_b_q  <= 1'b0;
      last_b_q   <= 1'b1;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      cnt_q      <= '0;
      idle_q     <= 1'b1;
    end else begin
      a_full_q   <= a_full_d;
      a_addr_q   <= a_addr_d;
      a_data_q   <= a_data_d;
      b_full_q   <= b_full_d;
      b_addr_q   <= b_addr_d;
      b_data_q   <= b_data_d;
      age_diff_q <= age_diff_d;
      older_b_q  <= older_b_d;
      last_b_q   <= last_b_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      cnt_q      <= cnt_d;
      idle_q     <= idle_d;
    end
  end

  assign rf_wr_en     = wr_en_q;
  assign rf_wr_addr   = wr_addr_q;
  assign rf_wr_data   = wr_data_q;
  assign conflict_cnt = cnt_q;
  assign idle         = idle_q;

`ifdef RF_WB_FORWARD_EN
  // With equal ages the buffer not granted now writes later, so it counts as younger
  logic young_b_c;
  assign young_b_c = age_diff_q ? !older_b_q : grant_a_c;

  function automatic logic [DATA_W:0] fwd_lookup(input logic [ADDR_W-1:0] ra);
    logic hit_a, hit_b, hit_o;
    logic [DATA_W:0] res;
    hit_a = a_full_q && (a_addr_q == ra);
    hit_b = b_full_q && (b_addr_q == ra);
    hit_o = wr_en_q && (wr_addr_q == ra);
    res   = '0;
    if (ra != ADDR_W'(0)) begin
      if (hit_a && hit_b) res = {1'b1, (young_b_c ? b_data_q : a_data_q)};
      else if (hit_a)     res = {1'b1, a_data_q};
      else if (hit_b)     res = {1'b1, b_data_q};
      else if (hit_o)     res = {1'b1, wr_data_q};
    end
    return res;
  endfunction

  always_comb begin
    {fwd_hit1, fwd_data1} = fwd_lookup(fwd_addr1);
    {fwd_hit2, fwd_data2} = fwd_lookup(fwd_addr2);
  end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: arrival-stamp reference model feeds an expected-write queue.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic [15:0] conflict_cnt;
  logic        idle;
`ifdef RF_WB_FORWARD_EN
  logic [4:0]  fwd_addr1 = '0, fwd_addr2 = '0;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
`endif

  rf_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
`ifdef RF_WB_FORWARD_EN
    .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
`endif
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .conflict_cnt(conflict_cnt), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    logic [4:0]  addr;
    logic [31:0] data;
    int          stamp;
  } slot_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          due;
  } wr_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_exp_wr = 0;
  int n_got_wr = 0;
  wr_t exp_q[$];

  // reference model state
  slot_t       m_a, m_b;
  bit          m_last_b;
  int          m_cnt;
  bit          m_wr_en;
  bit          m_idle;
  int          tcount = 0;

  // what each source currently presents; cleared once accepted
  bit          pa_v, pb_v;
  logic [4:0]  pa_addr, pb_addr;
  logic [31:0] pa_data, pb_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_a.v = 0; m_b.v = 0; m_last_b = 1; m_cnt = 0; m_wr_en = 0; m_idle = 1;
  endtask

  // One clock: drive at negedge, compare ready/idle/count, advance the model
  task automatic tick(input bit do_rst);
    bit ga, gb, ra, rb, xa, xb;
    slot_t g;
    @(negedge clk);
    rst = do_rst;
    a_valid = pa_v; a_addr = pa_addr; a_data = pa_data;
    b_valid = pb_v; b_addr = pb_addr; b_data = pb_data;
    #1;
    ga = 0; gb = 0;
    if (m_a.v && m_b.v) begin
      if (m_a.stamp < m_b.stamp)      ga = 1;
      else if (m_b.stamp < m_a.stamp) gb = 1;
      else if (m_last_b)              ga = 1;
      else                            gb = 1;
    end else begin
      ga = m_a.v; gb = m_b.v;
    end
    ra = !m_a.v || ga;
    rb = !m_b.v || gb;
    chk("a_ready", 32'(a_ready), 32'(ra));
    chk("b_ready", 32'(b_ready), 32'(rb));
    chk("idle", 32'(idle), 32'(m_idle));
    chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
    xa = pa_v && ra;
    xb = pb_v && rb;
    if (do_rst) begin
      model_reset();
    end else begin
      if (m_a.v && m_b.v && m_cnt != 65535) m_cnt++;
      m_wr_en = 0;
      if (ga || gb) begin
        g = ga ? m_a : m_b;
        m_last_b = gb;
        if (g.addr != 5'd0) begin
          m_wr_en = 1;
          exp_q.push_back('{addr: g.addr, data: g.data, due: cyc + 1});
          n_exp_wr++;
        end
      end
      if (ga) m_a.v = 0;
      if (gb) m_b.v = 0;
      if (xa) m_a = '{v: 1, addr: pa_addr, data: pa_data, stamp: tcount};
      if (xb) m_b = '{v: 1, addr: pb_addr, data: pb_data, stamp: tcount};
      m_idle = !m_a.v && !m_b.v && !m_wr_en;
      if (xa) pa_v = 0;
      if (xb) pb_v = 0;
    end
    tcount++;
  endtask

  task automatic set_a(input logic [4:0] ad, input logic [31:0] d);
    pa_v = 1; pa_addr = ad; pa_data = d;
  endtask

  task automatic set_b(input logic [4:0] ad, input logic [31:0] d);
    pb_v = 1; pb_addr = ad; pb_data = d;
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((pa_v || pb_v || !m_idle) && n < max_cycles) begin
      tick(0);
      n++;
    end
    tick(0);
    tick(0);
    n_checks++;
    if (pa_v || pb_v || !m_idle) begin
      n_fail++;
      $display("FAIL drain_timeout: still busy after %0d cycles, required idle", max_cycles);
    end
  endtask

  // Monitor: every observed write must match the head of the expected queue, on time
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rf_wr_en === 1'b1) begin
        n_got_wr++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: addr %0d data 0x%0h, required no write", rf_wr_addr, rf_wr_data);
        end else begin
          e = exp_q.pop_front();
          if (rf_wr_addr !== e.addr || rf_wr_data !== e.data || cyc != e.due) begin
            n_fail++;
            $display("FAIL write: got addr %0d data 0x%0h cycle %0d, required addr %0d data 0x%0h cycle %0d",
                     rf_wr_addr, rf_wr_data, cyc, e.addr, e.data, e.due);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int na, nb;
    pa_v = 0; pb_v = 0; pa_addr = '0; pb_addr = '0; pa_data = '0; pb_data = '0;
    rst = 1; a_valid = 0; b_valid = 0; a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    model_reset();
    tick(1);
    tick(1);
    chk("reset_wr_en", 32'(rf_wr_en), 32'd0);
    chk("reset_wr_addr", 32'(rf_wr_addr), 32'd0);
    chk("reset_wr_data", rf_wr_data, 32'd0);

    // single A writeback
    set_a(5'd5, 32'hDEADBEEF);
    drain(20);

    // simultaneous A/B after a fresh reset: A first, exactly one conflict cycle
    tick(1);
    base = 32'(conflict_cnt);
    set_a(5'd3, 32'h11);
    set_b(5'd4, 32'h22);
    drain(20);
    chk("tie_conflict_delta", 32'(conflict_cnt) - 32'(base), 32'd1);

    // age order: B blocked by a tie, then a younger A arrives
    set_a(5'd1, 32'h1);
    set_b(5'd2, 32'h2);
    tick(0);
    set_b(5'd7, 32'h70);
    tick(0);
    set_a(5'd8, 32'h80);
    drain(20);

    // x0 writeback is accepted and swallowed
    set_a(5'd0, 32'hFFFF);
    drain(20);
    set_b(5'd0, 32'h1234);
    drain(20);

    // both sources streaming for 20 cycles
    na = 0; nb = 0;
    for (int i = 0; i < 20; i++) begin
      if (!pa_v) begin set_a(5'(1 + (na % 15)), 32'hA000_0000 + 32'(na)); na++; end
      if (!pb_v) begin set_b(5'(16 + (nb % 16)), 32'hB000_0000 + 32'(nb)); nb++; end
      tick(0);
    end
    drain(40);

    // A streaming alone keeps one entry per cycle
    for (int i = 0; i < 8; i++) begin
      set_a(5'(9 + i), 32'hC0 + 32'(i));
      tick(0);
      chk("a_stream_accept", 32'(pa_v), 32'd0);
    end
    drain(20);

    // reset with both buffers full discards them
    set_a(5'd10, 32'hAA);
    set_b(5'd20, 32'hBB);
    tick(0);
    tick(1);
    pa_v = 0; pb_v = 0;
    drain(10);

    // random traffic with sources holding until accepted
    for (int i = 0; i < 400; i++) begin
      if (!pa_v && ($urandom_range(0, 3) != 0))
        set_a(5'($urandom_range(0, 15)), $urandom);
      if (!pb_v && ($urandom_range(0, 2) != 0))
        set_b(($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(16, 31)), $urandom);
      tick(($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0);
    end
    drain(40);

    chk("pending_expected_writes", 32'(exp_q.size()), 32'd0);
    chk("write_count", 32'(n_got_wr), 32'(n_exp_wr));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Writeback scheduler in front of the 32x32 register file's single write port (wr_rd_en / addr_wr / write_port).
- Shares that port between two writeback sources: source A (ALU result path) and source B (load/memory result path).
- Each source has a one-entry holding buffer. Pending entries are granted in arrival order, with round-robin tie-break.
- Writes to x0 are discarded. The register file writes on negedge, so a granted value is readable by combinational reads in the cycle after grant.

Parameters:
- DATA_W, 32, width of writeback data.
- ADDR_W, 5, register address width (32 registers).
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- a_valid  input  1  source A has a writeback.
- a_ready  output  1  source A entry accepted this cycle.
- a_addr  input  ADDR_W  destination register, source A.
- a_data  input  DATA_W  result, source A.
- b_valid  input  1  source B has a writeback.
- b_ready  output  1  source B entry accepted this cycle.
- b_addr  input  ADDR_W  destination register, source B.
- b_data  input  DATA_W  result, source B.
- rf_wr_en  output  1  drives register-file wr_rd_en.
- rf_wr_addr  output  ADDR_W  drives addr_wr.
- rf_wr_data  output  DATA_W  drives write_port.
- conflict_cnt  output  CNT_W  cycles in which both buffers were pending.
- idle  output  1  both buffers empty and rf_wr_en low.

Behaviour:
- Reset (synchronous, active-high; clk and rst per codebase naming):
  - buffers empty, age bit 0, last_grant = B (so A wins the first tie).
  - rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, conflict_cnt=0, idle=1.
  - Reset mid-operation discards buffered entries; no write is issued for them.
- Handshake, per source X:
  - X_ready = !bufX_full | grantX, where grantX is the combinational grant this cycle.
  - Transfer on posedge when X_valid & X_ready; addr and data are captured into bufX.
  - A source streaming alone sustains 1 entry/cycle.
- Age tracking:
  - Capturing into an empty buffer while the other buffer is already full makes the new entry younger.
  - Simultaneous capture into both buffers gives equal age.
- Grant (combinational, in the cycle after capture):
  - Only one buffer full -> grant it.
  - Both full and ages differ -> grant the older.
  - Both full with equal age -> grant the source opposite to last_grant; last_grant updates on every grant.
- Output register, at the posedge that ends a grant cycle:
  - rf_wr_en <= (granted addr != 0); rf_wr_addr and rf_wr_data <= granted entry; the granted buffer clears.
  - If nothing is granted: rf_wr_en <= 0; addr and data hold their last values.
- Latency:
  - Handshake at edge t -> buffered after t -> rf_wr_en high in cycle t+2.
  - Register file write at the negedge within t+2; readable via combinational read in t+2 second half / t+3.
- x0 entries:
  - accepted, buffered and granted normally.
  - rf_wr_en stays 0 for that grant slot.
- conflict_cnt: +1 each cycle both buffers are full; saturates at all-ones.
- Upstream rule: A and B never present the same nonzero address in the same cycle. If violated, the round-robin order applies and no error is flagged.
- Back-pressure example: both streaming continuously -> each source sees ready on alternate cycles; no entry is lost or duplicated.

Optional Feature:
- Macro: RF_WB_FORWARD_EN.
- Defined adds ports:
  - fwd_addr1, fwd_addr2  input  ADDR_W.
  - fwd_hit1, fwd_hit2  output  1.
  - fwd_data1, fwd_data2  output  DATA_W.
- Defined, hit rule: fwd_hitN=1 when fwd_addrN != 0 and matches a full buffer or the registered rf_wr_addr with rf_wr_en=1.
- Defined, priority: youngest match wins, i.e. younger buffer > older buffer > output register.
- Defined, timing: purely combinational from the current state.
- Not defined: ports absent; no forwarding logic.

Test Plan:
- A only: a_valid=1, a_addr=5, a_data=0xDEADBEEF at t -> a_ready=1; rf_wr_en=1, rf_wr_addr=5, rf_wr_data=0xDEADBEEF in t+2 only; idle=1 in t+3.
- Simultaneous A(addr 3, 0x11) and B(addr 4, 0x22) after reset -> A written in t+2, B in t+3; b_ready=0 in t+1; conflict_cnt=1.
- Age order: B(addr 7, 0x70) at t, A(addr 8, 0x80) at t+1 while B is blocked by a prior tie -> B written before A regardless of last_grant.
- x0: A addr=0, data=0xFFFF -> a_ready=1, rf_wr_en stays 0 throughout, buffer clears, idle returns to 1.
- Stream: A and B valid every cycle for 20 cycles with distinct addrs -> exactly 20 writes, alternating A/B; no drops or duplicates; conflict_cnt=19.
- Reset mid-flight: both buffers full, rst=1 for one cycle -> rf_wr_en=0 next cycle, conflict_cnt=0, idle=1, no pending write emitted.
